rr_grant_arbiter: RTL
=====================

# rr_grant_arbiter

Four-way round-robin arbiter that shares one resource among four requesters and drives a registered one-hot grant. The grant vector has the same one-hot 4-bit format as the 2-to-4 decoder output. The block sits between the requesting units and the shared resource's select/enable inputs. It holds a grant until the owner releases its request, or, optionally, until a hold-time limit expires.

## Interface
- MAX_HOLD, 8: maximum consecutive grant cycles per ownership when the timeout feature is compiled in; legal range 2..255
- CNT_W, 8: width of the hold counter; must satisfy 2^CNT_W > MAX_HOLD
- clk_i  input  1  clock; all state changes on rising edge
- reset  input  1  asynchronous, active-high reset
- req  input  4  request lines; requester k holds req[k] high while it needs or uses the resource
- gnt  output  4  registered one-hot grant; all-zero when no owner
- gnt_id  output  2  binary index of current owner; valid only while gnt_valid=1
- gnt_valid  output  1  high while gnt is nonzero
- timeout  output  1  one-cycle pulse when a grant is revoked by the hold limit

## Operation
- State machine with two states, IDLE and GRANT.
- IDLE:
  - gnt=0, gnt_valid=0.
  - If req≠0 at a clock edge, pick winner w, go to GRANT, set gnt=(1<<w), gnt_id=w, ptr=w, hold_cnt=0.
  - If req=0, stay in IDLE.
- Winner search order: ptr+1, ptr+2, ptr+3, ptr, all mod 4. The first asserted req in that order wins, so the last owner has lowest priority.
- GRANT, owner released:
  - If req[gnt_id]=0 at an edge, go to IDLE and clear gnt, gnt_valid and hold_cnt.
  - Requests from other requesters never preempt the owner.
- GRANT, owner still requesting: hold_cnt increments by 1 each cycle. It saturates at MAX_HOLD-1 when the timeout feature is compiled out.
- Re-arbitration happens only from IDLE, so there is exactly one gnt=0 cycle between consecutive owners. This includes the same requester re-requesting.
- gnt_id and ptr keep their last values while in IDLE.
- Reset values: state=IDLE, gnt=4'b0000, gnt_id=2'b00, gnt_valid=0, timeout=0, hold_cnt=0, ptr=2'b11. With ptr=3, requester 0 has highest priority after reset.

## Timing
- Grant latency: req sampled high at edge N gives gnt valid after edge N, i.e. one cycle.
- Release latency: req[gnt_id] sampled low at edge M gives gnt=0 after edge M.
- Earliest next grant is after edge M+1.
- Timeout boundary (only with the macro):
  - Condition: at an edge in GRANT where hold_cnt==MAX_HOLD-1 and req[gnt_id]=1.
  - Response: go to IDLE, gnt=0, timeout=1 for exactly one cycle, ptr stays at the revoked owner.
  - Result: the grant is visible for exactly MAX_HOLD cycles.
- Simultaneous release and timeout condition on the same edge: treated as a normal release, timeout stays 0.
- Requester re-asserting immediately after a timeout competes normally. It has lowest priority because ptr points at it.
- reset asserted mid-grant: gnt, gnt_valid and timeout drop immediately (asynchronously), without waiting for a clock edge.
- reset deasserted: the first arbitration occurs at the first edge after deassertion on which req≠0.
- Invariant: gnt is always one-hot or zero; gnt_valid == (gnt≠0); gnt == (1<<gnt_id) whenever gnt_valid=1.

## Configuration
- Macro: ARB_TIMEOUT_EN.
- Defined: hold-limit logic present. A grant is revoked after MAX_HOLD cycles and timeout pulses as described under Timing.
- Undefined:
  - No revocation; an owner keeps the grant for as long as it holds its req.
  - timeout is tied to 0.
  - hold_cnt saturates at MAX_HOLD-1 and has no effect on the outputs.

## Test plan
- Reset, then req=4'b1111 held: gnt=4'b0001 one cycle after req. Release req[0], then gnt=0 for one cycle, then gnt=4'b0010, gnt_id=1.
- req=4'b1111 with every owner releasing after 2 cycles: grant order 0,1,2,3,0. Each grant lasts 2 cycles with one idle cycle between grants.
- Owner 2 holding, req[1] and req[3] asserted: gnt stays 4'b0100 until req[2] drops, then gnt=4'b1000.
- ARB_TIMEOUT_EN, MAX_HOLD=4, req=4'b0001 held forever:
  - gnt=4'b0001 for exactly 4 cycles, then gnt=0 with timeout=1 for 1 cycle.
  - gnt=4'b0001 is regranted one cycle after that.
  - With the macro undefined, gnt stays 4'b0001 indefinitely and timeout stays 0.
- ARB_TIMEOUT_EN, MAX_HOLD=4: req[0] dropped on the same edge that hits the limit gives gnt=0 and timeout=0.
- Assert reset for 1 cycle mid-grant with gnt=4'b0100: gnt=0 and gnt_valid=0 immediately. After release with req=4'b0110, the first grant is 4'b0010.

Source files
------------

// File: rtl/rr_grant_arbiter.sv
// Four-way round-robin arbiter with a registered one-hot grant held until the owner releases.
// Define ARB_TIMEOUT_EN to revoke a grant after MAX_HOLD cycles and pulse timeout.
module rr_grant_arbiter #(
   parameter int MAX_HOLD = 8,
   parameter int CNT_W    = 8
) (
   input  logic       clk_i,
   input  logic       reset,
   input  logic [3:0] req,
   output logic [3:0] gnt,
   output logic [1:0] gnt_id,
   output logic       gnt_valid,
   output logic       timeout,
   output logic       dbg_state_o
);

   localparam logic [0:0] S_IDLE  = 1'b0;
   localparam logic [0:0] S_GRANT = 1'b1;
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

   // Handshake: req[k] is a level request; the owner keeps gnt while it holds
   // req[k] high, and dropping req[k] is the only way to hand the resource back
   // (apart from the optional hold limit). There is no backpressure path.
   logic [0:0]       state_q, state_d;
   logic [3:0]       gnt_q, gnt_d;
   logic [1:0]       gnt_id_q, gnt_id_d;
   logic [1:0]       ptr_q, ptr_d;
   logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
   logic             timeout_q, timeout_d;

   logic             win_found;
   logic [1:0]       win_id;
   logic [1:0]       cand;

   // Search starts just after the last owner, so the last owner is tried last.
   always_comb begin
      win_found = 1'b0;
      win_id    = ptr_q;
      cand      = ptr_q;
      for (int i = 1; i <= 4; i++) begin
         cand = ptr_q + 2'(i);
         if (!win_found && req[cand]) begin
            win_found = 1'b1;
            win_id    = cand;
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      gnt_d      = gnt_q;
      gnt_id_d   = gnt_id_q;
      ptr_d      = ptr_q;
      hold_cnt_d = hold_cnt_q;
      timeout_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (win_found) begin
               state_d    = S_GRANT;
               gnt_d      = 4'(1) << win_id;
               gnt_id_d   = win_id;
               ptr_d      = win_id;
               hold_cnt_d = '0;
            end
         end
         S_GRANT: begin
            if (!req[gnt_id_q]) begin
               state_d    = S_IDLE;
               gnt_d      = 4'b0000;
               hold_cnt_d = '0;
            end
`ifdef ARB_TIMEOUT_EN
            else if (hold_cnt_q == HOLD_LAST) begin
               state_d    = S_IDLE;
               gnt_d      = 4'b0000;
               hold_cnt_d = '0;
               timeout_d  = 1'b1;
            end
`endif
            else if (hold_cnt_q != HOLD_LAST) begin
               hold_cnt_d = hold_cnt_q + 1'b1;
            end
         end
         default: begin
            state_d    = S_IDLE;
            gnt_d      = 4'b0000;
            hold_cnt_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge reset) begin
      if (reset) begin
         state_q    <= S_IDLE;
         gnt_q      <= 4'b0000;
         gnt_id_q   <= 2'b00;
         ptr_q      <= 2'b11;
         hold_cnt_q <= '0;
         timeout_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         gnt_q      <= gnt_d;
         gnt_id_q   <= gnt_id_d;
         ptr_q      <= ptr_d;
         hold_cnt_q <= hold_cnt_d;
         timeout_q  <= timeout_d;
      end
   end

   assign gnt         = gnt_q;
   assign gnt_id      = gnt_id_q;
   assign gnt_valid   = |gnt_q;
   assign timeout     = timeout_q;
   assign dbg_state_o = state_q[0];

endmodule
